// File: rtl/pc_fetch_control_pkg.sv
// Shared MIPS fetch package: PC width/reset defaults,
// fetch FSM state encoding and the sequential PC increment.
package pc_fetch_control_pkg;

    localparam int          NBITS_DEFAULT    = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int          PC_INCR          = 4;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_PEND   = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    typedef enum logic [1:0] {
        RUN    = ST_RUN,
        HOLD   = ST_HOLD,
        PEND   = ST_PEND,
        HALTED = ST_HALTED
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_control_pc_register.sv
// NBITS-wide PC register, async active-low reset to RESET_PC.
// Ports: i_clk, i_reset_n, i_load (enable), i_d (next PC), o_q (PC).
module pc_register #(
    parameter int               NBITS    = 32,
    parameter logic [NBITS-1:0] RESET_PC = '0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_d,
    output logic [NBITS-1:0] o_q
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_q <= RESET_PC;
        end else if (i_load) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/pc_fetch_control.sv
// Fetch-stage PC owner: next-PC selection, buffered redirects, halt.
// Ports: i_clk, i_reset_n, i_enable, i_stall, i_halt,
//   i_branch_taken/i_branch_target, i_jump/i_jump_target,
//   o_pc (fetch address), o_pc4 (o_pc+4), o_flush (IF/ID squash),
//   o_halted (fetch stopped until reset).
module pc_fetch_control
    import pc_fetch_control_pkg::*;
#(
    parameter int               NBITS    = NBITS_DEFAULT,
    parameter logic [NBITS-1:0] RESET_PC = NBITS'(RESET_PC_DEFAULT)
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_stall,
    input  logic             i_halt,
    input  logic             i_branch_taken,
    input  logic [NBITS-1:0] i_branch_target,
    input  logic             i_jump,
    input  logic [NBITS-1:0] i_jump_target,
    output logic [NBITS-1:0] o_pc,
    output logic [NBITS-1:0] o_pc4,
    output logic             o_flush,
    output logic             o_halted
);

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [NBITS-1:0] pend;
    logic [NBITS-1:0] pend_n;
    logic             flush_n;
    logic             pc_load;
    logic [NBITS-1:0] pc_next;
    logic [NBITS-1:0] tgt_raw;
    logic [NBITS-1:0] tgt;
    logic             advance;
    logic             redirect;

    assign advance  = i_enable & ~i_stall;
    assign redirect = i_jump | i_branch_taken;

    // Jump wins over a simultaneous taken branch.
    assign tgt_raw = i_jump ? i_jump_target
                            : i_branch_target;
    assign tgt     = {tgt_raw[NBITS-1:2], 2'b00};

    // Natural modulo-2^NBITS wrap.
    assign o_pc4 = o_pc + NBITS'(PC_INCR);

    assign o_halted = (state == HALTED);

    pc_register #(
        .NBITS    (NBITS),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_load    (pc_load),
        .i_d       (pc_next),
        .o_q       (o_pc)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= RUN;
            pend    <= '0;
            o_flush <= 1'b0;
        end else begin
            state   <= state_n;
            pend    <= pend_n;
            o_flush <= flush_n;
        end
    end

    always_comb begin
        state_n = state;
        pend_n  = pend;
        flush_n = 1'b0;
        pc_load = 1'b0;
        pc_next = o_pc4;

        if (state == HALTED) begin
            state_n = HALTED;
        end else if (i_halt) begin
            state_n = HALTED;
            pend_n  = '0;
        end else begin
            unique case (state)
                RUN, HOLD: begin
                    if (redirect && advance) begin
                        pc_load = 1'b1;
                        pc_next = tgt;
                        flush_n = 1'b1;
                        state_n = RUN;
                    end else if (redirect) begin
                        pend_n  = tgt;
                        state_n = PEND;
                    end else if (advance) begin
                        pc_load = 1'b1;
                        state_n = RUN;
                    end else begin
                        state_n = HOLD;
                    end
                end
                PEND: begin
                    if (advance) begin
                        pc_load = 1'b1;
                        // A fresh redirect supersedes the buffered one.
                        pc_next = redirect ? tgt : pend;
                        flush_n = 1'b1;
                        pend_n  = '0;
                        state_n = RUN;
                    end else if (redirect) begin
                        pend_n  = tgt;
                    end
                end
                default: begin
                    state_n = HALTED;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_control.sv
// Directed self-checking bench for pc_fetch_control.
// Second instance uses RESET_PC=FFFF_FFF8 to cover PC wrap.
module tb_pc_fetch_control;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        stall;
    logic        halt;
    logic        br;
    logic [31:0] br_tgt;
    logic        jmp;
    logic [31:0] j_tgt;

    logic [31:0] pc;
    logic [31:0] pc4;
    logic        flush;
    logic        halted;
    logic [31:0] wpc;
    logic [31:0] wpc4;
    logic        wflush;
    logic        whalted;

    int n_chk;
    int n_bad;

    pc_fetch_control dut (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_enable        (en),
        .i_stall         (stall),
        .i_halt          (halt),
        .i_branch_taken  (br),
        .i_branch_target (br_tgt),
        .i_jump          (jmp),
        .i_jump_target   (j_tgt),
        .o_pc            (pc),
        .o_pc4           (pc4),
        .o_flush         (flush),
        .o_halted        (halted)
    );

    pc_fetch_control #(
        .NBITS    (32),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .i_clk           (clk),
        .i_reset_n       (rst_n),
        .i_enable        (en),
        .i_stall         (stall),
        .i_halt          (halt),
        .i_branch_taken  (br),
        .i_branch_target (br_tgt),
        .i_jump          (jmp),
        .i_jump_target   (j_tgt),
        .o_pc            (wpc),
        .o_pc4           (wpc4),
        .o_flush         (wflush),
        .o_halted        (whalted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pc(input string tag,
                          input logic [31:0] e_pc,
                          input logic e_fl);
        chk({tag, ".pc"}, pc, e_pc);
        chk({tag, ".pc4"}, pc4, e_pc + 32'd4);
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, e_fl});
    endtask

    task automatic idle();
        br  = 1'b0;
        jmp = 1'b0;
    endtask

    initial begin
        n_chk  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        en     = 1'b1;
        stall  = 1'b0;
        halt   = 1'b0;
        br     = 1'b0;
        jmp    = 1'b0;
        br_tgt = '0;
        j_tgt  = '0;

        tick();
        tick();
        chk_pc("rst", 32'h0, 1'b0);
        chk("rst.halted", {31'd0, halted}, 32'd0);
        chk("rst.wpc", wpc, 32'hFFFF_FFF8);
        rst_n = 1'b1;

        // free run, plus wrap on the second instance
        tick();
        chk_pc("run1", 32'h4, 1'b0);
        chk("wrap1.pc", wpc, 32'hFFFF_FFFC);
        chk("wrap1.pc4", wpc4, 32'h0);
        tick();
        chk_pc("run2", 32'h8, 1'b0);
        chk("wrap2.pc", wpc, 32'h0);
        tick();
        chk_pc("run3", 32'hC, 1'b0);
        tick();
        chk_pc("run4", 32'h10, 1'b0);

        // taken branch at PC=0x10
        br     = 1'b1;
        br_tgt = 32'h40;
        tick();
        chk_pc("br", 32'h40, 1'b1);
        idle();
        tick();
        chk_pc("br+1", 32'h44, 1'b0);

        // jump beats branch
        jmp    = 1'b1;
        j_tgt  = 32'h100;
        br     = 1'b1;
        br_tgt = 32'h80;
        tick();
        chk_pc("jb", 32'h100, 1'b1);
        idle();
        tick();
        chk_pc("jb+1", 32'h104, 1'b0);

        // low target bits are cleared
        jmp   = 1'b1;
        j_tgt = 32'h43;
        tick();
        chk_pc("mask", 32'h40, 1'b1);
        j_tgt = 32'h20;
        tick();
        chk_pc("to20", 32'h20, 1'b1);
        idle();

        // stall buffering, newest redirect wins
        stall  = 1'b1;
        br     = 1'b1;
        br_tgt = 32'h200;
        tick();
        chk_pc("st0", 32'h20, 1'b0);
        idle();
        tick();
        chk_pc("st1", 32'h20, 1'b0);
        jmp   = 1'b1;
        j_tgt = 32'h300;
        tick();
        chk_pc("st2", 32'h20, 1'b0);
        idle();
        tick();
        chk_pc("st3", 32'h20, 1'b0);
        stall = 1'b0;
        tick();
        chk_pc("stx", 32'h300, 1'b1);
        tick();
        chk_pc("stx+1", 32'h304, 1'b0);

        // debug gate off then on
        en = 1'b0;
        tick();
        chk_pc("hold", 32'h304, 1'b0);
        en = 1'b1;
        tick();
        chk_pc("hold+1", 32'h308, 1'b0);

        // reset mid-PEND drops the buffered target
        stall  = 1'b1;
        br     = 1'b1;
        br_tgt = 32'h500;
        tick();
        idle();
        stall = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_pc("prst", 32'h0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_pc("prst+1", 32'h4, 1'b0);
        tick();
        chk_pc("prst+2", 32'h8, 1'b0);

        // halt at PC=0x8
        halt = 1'b1;
        tick();
        chk_pc("halt", 32'h8, 1'b0);
        chk("halt.halted", {31'd0, halted}, 32'd1);
        halt   = 1'b0;
        br     = 1'b1;
        br_tgt = 32'h40;
        tick();
        chk_pc("halt+1", 32'h8, 1'b0);
        chk("halt+1.halted", {31'd0, halted}, 32'd1);
        tick();
        chk_pc("halt+2", 32'h8, 1'b0);
        idle();

        // async reset out of HALTED
        rst_n = 1'b0;
        #1;
        chk_pc("hrst", 32'h0, 1'b0);
        chk("hrst.halted", {31'd0, halted}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_pc("hrst+1", 32'h4, 1'b0);

        $display("test done: total=%0d bad=%0d",
                 n_chk, n_bad);
        $finish;
    end

endmodule
